// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one RAM port between instruction and data traffic.
// One access in flight; data wins ties unless it was granted last; stalled accesses time out.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iren,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dren,
    input  logic        dwen,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ack,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StDacc, StIacc} state_e;

    state_e      state_q, state_d;
    logic        last_data_q, last_data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic        wr_q, wr_d;

    logic d_pend;
    logic req_live;
    logic busy;

    assign d_pend = dren | dwen;

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        addr_d      = addr_q;
        store_d     = store_q;
        wr_d        = wr_q;
        req_live    = 1'b0;

        case (state_q)
            StIdle: begin
                if (d_pend && !(iren && last_data_q)) begin
                    state_d     = StDacc;
                    addr_d      = daddr;
                    store_d     = dstore;
                    wr_d        = dwen;
                    last_data_d = 1'b1;
                    cnt_d       = 8'd0;
                end else if (iren) begin
                    state_d     = StIacc;
                    addr_d      = iaddr;
                    store_d     = 32'd0;
                    wr_d        = 1'b0;
                    last_data_d = 1'b0;
                    cnt_d       = 8'd0;
                end
            end
            StDacc, StIacc: begin
                req_live = (state_q == StDacc) ? d_pend : iren;
                if (ram_ack) begin
                    state_d = StIdle;
                end else if (!req_live) begin
                    // Requester withdrew: drop the access silently.
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset masks the outputs in the same cycle so a concurrent ack never produces a hit.
    always_comb begin
        busy      = (state_q != StIdle) && !RST;
        ram_ren   = busy && !wr_q;
        ram_wen   = busy && wr_q;
        ram_addr  = busy ? addr_q : 32'd0;
        ram_store = busy ? store_q : 32'd0;
        dhit      = (state_q == StDacc) && ram_ack && !RST;
        ihit      = (state_q == StIacc) && ram_ack && !RST;
        dload     = dhit ? ram_load : 32'd0;
        iload     = ihit ? ram_load : 32'd0;
        err       = err_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            last_data_q <= 1'b0;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
            addr_q      <= 32'd0;
            store_q     <= 32'd0;
            wr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            store_q     <= store_d;
            wr_q        <= wr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences,
// then random traffic against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned TO = 16;

    logic        CLK = 1'b0;
    logic        RST, iren, dren, dwen, ram_ack;
    logic [31:0] iaddr, daddr, dstore, ram_load;
    logic        ihit, dhit, ram_ren, ram_wen, err;
    logic [31:0] iload, dload, ram_addr, ram_store;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .iren(iren), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ack(ram_ack),
        .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic drive(input logic r, input logic i, input logic d, input logic w,
                         input logic a);
        RST = r; iren = i; dren = d; dwen = w; ram_ack = a;
    endtask

    typedef struct {
        logic        rst, ir, dr, dw, ack;
        logic        ren, wen, ih, dh;
        logic [31:0] addr, store;
    } vec_t;

    vec_t vecs[14];

    // Transaction-level reference model.
    logic        m_busy, m_data, m_wr, m_last_data, m_err;
    logic [31:0] m_addr, m_store;
    int          m_cycles;

    task automatic model_reset();
        m_busy = 0; m_data = 0; m_wr = 0; m_last_data = 0; m_err = 0;
        m_addr = 0; m_store = 0; m_cycles = 0;
    endtask

    task automatic model_check();
        logic act_on, exp_dh, exp_ih;
        act_on = m_busy && !RST;
        exp_dh = act_on && m_data && ram_ack;
        exp_ih = act_on && !m_data && ram_ack;
        check("rnd ram_ren", 32'(ram_ren), 32'(act_on && !m_wr));
        check("rnd ram_wen", 32'(ram_wen), 32'(act_on && m_wr));
        check("rnd ram_addr", ram_addr, act_on ? m_addr : 32'd0);
        check("rnd ram_store", ram_store, act_on ? m_store : 32'd0);
        check("rnd dhit", 32'(dhit), 32'(exp_dh));
        check("rnd ihit", 32'(ihit), 32'(exp_ih));
        check("rnd dload", dload, exp_dh ? ram_load : 32'd0);
        check("rnd iload", iload, exp_ih ? ram_load : 32'd0);
        check("rnd err", 32'(err), 32'(m_err));
    endtask

    task automatic model_step();
        logic want_d, still;
        if (RST) begin
            model_reset();
        end else if (!m_busy) begin
            want_d = dren | dwen;
            if (want_d && !(iren && m_last_data)) begin
                m_busy = 1; m_data = 1; m_wr = dwen; m_addr = daddr; m_store = dstore;
                m_last_data = 1; m_cycles = 0;
            end else if (iren) begin
                m_busy = 1; m_data = 0; m_wr = 0; m_addr = iaddr; m_store = 0;
                m_last_data = 0; m_cycles = 0;
            end
        end else begin
            still = m_data ? (dren | dwen) : iren;
            m_cycles++;
            if (ram_ack || !still) begin
                m_busy = 0;
            end else if (m_cycles == TO) begin
                m_busy = 0;
                m_err  = 1;
            end
        end
    endtask

    initial begin
        int ren_cnt;
        logic seen_dhit, seen_ren;

        drive(1, 0, 0, 0, 0);
        iaddr = 32'h40; daddr = 32'h100; dstore = 32'h1234_5678; ram_load = 32'hCAFE_F00D;

        //           rst ir dr dw ack  ren wen ih dh  addr          store
        vecs[0]  = '{1, 1, 1, 0, 1,   0, 0, 0, 0,  32'h0,        32'h0};
        vecs[1]  = '{1, 1, 1, 0, 1,   0, 0, 0, 0,  32'h0,        32'h0};
        vecs[2]  = '{0, 1, 1, 0, 1,   0, 0, 0, 0,  32'h0,        32'h0};
        vecs[3]  = '{0, 1, 1, 0, 1,   1, 0, 0, 1,  32'h100,      32'h1234_5678};
        vecs[4]  = '{0, 1, 1, 0, 1,   0, 0, 0, 0,  32'h0,        32'h0};
        vecs[5]  = '{0, 1, 1, 0, 1,   1, 0, 1, 0,  32'h40,       32'h0};
        vecs[6]  = '{0, 1, 1, 0, 1,   0, 0, 0, 0,  32'h0,        32'h0};
        vecs[7]  = '{0, 1, 1, 0, 1,   1, 0, 0, 1,  32'h100,      32'h1234_5678};
        vecs[8]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0,  32'h0,        32'h0};
        vecs[9]  = '{0, 0, 0, 1, 0,   0, 0, 0, 0,  32'h0,        32'h0};
        vecs[10] = '{0, 0, 0, 1, 1,   0, 1, 0, 1,  32'h100,      32'h1234_5678};
        vecs[11] = '{0, 0, 0, 0, 0,   0, 0, 0, 0,  32'h0,        32'h0};
        vecs[12] = '{0, 0, 1, 1, 0,   0, 0, 0, 0,  32'h0,        32'h0};
        vecs[13] = '{0, 0, 1, 1, 1,   0, 1, 0, 1,  32'h100,      32'h1234_5678};

        for (int k = 0; k < 14; k++) begin
            next_cycle();
            drive(vecs[k].rst, vecs[k].ir, vecs[k].dr, vecs[k].dw, vecs[k].ack);
            sample();
            check($sformatf("vec%0d ram_ren", k), 32'(ram_ren), 32'(vecs[k].ren));
            check($sformatf("vec%0d ram_wen", k), 32'(ram_wen), 32'(vecs[k].wen));
            check($sformatf("vec%0d ihit", k), 32'(ihit), 32'(vecs[k].ih));
            check($sformatf("vec%0d dhit", k), 32'(dhit), 32'(vecs[k].dh));
            check($sformatf("vec%0d ram_addr", k), ram_addr, vecs[k].addr);
            check($sformatf("vec%0d ram_store", k), ram_store, vecs[k].store);
            check($sformatf("vec%0d iload", k), iload, vecs[k].ih ? ram_load : 32'd0);
            check($sformatf("vec%0d dload", k), dload, vecs[k].dh ? ram_load : 32'd0);
            check($sformatf("vec%0d err", k), 32'(err), 32'd0);
        end

        // Instruction read, ack on second enable cycle; address change after grant ignored.
        next_cycle(); drive(1, 0, 0, 0, 0);
        next_cycle(); drive(0, 1, 0, 0, 0); iaddr = 32'h40; ram_load = 32'hDEAD_BEEF;
        sample(); check("iread grant ren", 32'(ram_ren), 32'd0);
        next_cycle(); iaddr = 32'h99;
        sample();
        check("iread w1 ren", 32'(ram_ren), 32'd1);
        check("iread w1 addr", ram_addr, 32'h40);
        check("iread w1 ihit", 32'(ihit), 32'd0);
        next_cycle(); ram_ack = 1;
        sample();
        check("iread ack ren", 32'(ram_ren), 32'd1);
        check("iread ack addr", ram_addr, 32'h40);
        check("iread ack ihit", 32'(ihit), 32'd1);
        check("iread ack iload", iload, 32'hDEAD_BEEF);
        next_cycle(); drive(0, 0, 0, 0, 0);
        sample();
        check("iread after ihit", 32'(ihit), 32'd0);
        check("iread after iload", iload, 32'd0);
        check("iread after ren", 32'(ram_ren), 32'd0);

        // Timeout: count enable cycles, drop the request once the access ends.
        next_cycle(); drive(0, 0, 1, 0, 0); daddr = 32'h200;
        ren_cnt = 0; seen_dhit = 0; seen_ren = 0;
        for (int c = 0; c < 40; c++) begin
            sample();
            if (ram_ren) begin ren_cnt++; seen_ren = 1; end
            if (dhit) seen_dhit = 1;
            next_cycle();
            if (seen_ren && !ram_ren) dren = 0;
        end
        check("timeout ren cycles", 32'(ren_cnt), 32'(TO));
        check("timeout no dhit", 32'(seen_dhit), 32'd0);
        sample();
        check("timeout err set", 32'(err), 32'd1);
        check("timeout idle", 32'(ram_ren), 32'd0);
        // err does not block a later access.
        next_cycle(); dren = 1;
        next_cycle(); ram_ack = 1;
        sample();
        check("post-err dhit", 32'(dhit), 32'd1);
        check("post-err err sticky", 32'(err), 32'd1);
        next_cycle(); drive(1, 0, 0, 0, 0);
        next_cycle(); drive(0, 0, 0, 0, 0);
        sample();
        check("err cleared by RST", 32'(err), 32'd0);

        // Abort: dren dropped on second DACC cycle.
        next_cycle(); drive(0, 0, 1, 0, 0);
        next_cycle(); sample(); check("abort d1 ren", 32'(ram_ren), 32'd1);
        next_cycle(); dren = 0;
        sample();
        check("abort d2 dhit", 32'(dhit), 32'd0);
        next_cycle(); ram_ack = 1;
        sample();
        check("abort ren off", 32'(ram_ren), 32'd0);
        check("abort no late dhit", 32'(dhit), 32'd0);

        // Reset during IACC, ack afterwards.
        next_cycle(); drive(0, 1, 0, 0, 0);
        next_cycle(); drive(1, 1, 0, 0, 1);
        sample();
        check("rst in iacc ihit", 32'(ihit), 32'd0);
        check("rst in iacc ren", 32'(ram_ren), 32'd0);
        next_cycle(); drive(0, 0, 0, 0, 1);
        sample();
        check("ack after rst ihit", 32'(ihit), 32'd0);
        check("ack after rst ren", 32'(ram_ren), 32'd0);

        // Random traffic against the reference model.
        next_cycle(); drive(1, 0, 0, 0, 0);
        sample(); model_reset();
        for (int c = 0; c < 600; c++) begin
            next_cycle();
            RST      = ($urandom_range(0, 63) == 0);
            iren     = ($urandom_range(0, 3) != 0);
            dren     = ($urandom_range(0, 2) == 0);
            dwen     = ($urandom_range(0, 3) == 0);
            ram_ack  = ($urandom_range(0, 5) == 0);
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ram_load = $urandom;
            sample();
            model_check();
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 16, number of RAM-enable cycles without ram_ack before an access is abandoned (range 2..255).
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 iren  in  1  instruction read request from request unit.
REQ-005 iaddr  in  32  instruction word address.
REQ-006 ihit  out  1  instruction access complete; iload valid this cycle.
REQ-007 iload  out  32  instruction data.
REQ-008 dren  in  1  data read request.
REQ-009 dwen  in  1  data write request.
REQ-010 daddr  in  32  data address.
REQ-011 dstore  in  32  data write value.
REQ-012 dhit  out  1  data access complete; dload valid this cycle for reads.
REQ-013 dload  out  32  data read value.
REQ-014 ram_ren  out  1  RAM read enable.
REQ-015 ram_wen  out  1  RAM write enable.
REQ-016 ram_addr  out  32  RAM address.
REQ-017 ram_store  out  32  RAM write data.
REQ-018 ram_load  in  32  RAM read data, valid with ram_ack.
REQ-019 ram_ack  in  1  RAM access complete this cycle.
REQ-020 err  out  1  sticky timeout flag.

Function
REQ-021 FSM states IDLE, DACC, IACC; one shared RAM port, one access in flight.
REQ-022 IDLE: pending data = dren|dwen, pending instr = iren; only one pending -> grant it; both pending -> grant data unless last_grant==data, then grant instr.
REQ-023 Grant in cycle N: latch address, dstore, op (write = dwen); set last_grant; enter DACC/IACC at N+1.
REQ-024 dwen&dren both high -> write; ram_ren=0.
REQ-025 ram_ren/ram_wen/ram_addr/ram_store decoded from state and latched regs only; enables 0 in IDLE; ram_ren and ram_wen never both 1.
REQ-026 Input address/data changes after grant ignored until access ends.
REQ-027 In DACC/IACC with ram_ack=1: hit asserted combinationally that cycle (dhit or ihit), dload/iload = ram_load pass-through, next state IDLE.
REQ-028 Minimum latency: request in cycle N, ack in N+1 -> hit in N+1; each extra wait cycle adds one.
REQ-029 ihit and dhit never both 1; hits are one-cycle pulses; dload/iload = 0 when corresponding hit = 0.
REQ-030 Requester deasserts its request during DACC/IACC with no ram_ack -> abort: IDLE next cycle, no hit, wait counter cleared; last_grant unchanged.
REQ-031 Wait counter (8-bit) clears on entry to DACC/IACC, increments each access cycle without ram_ack; when count reaches TIMEOUT-1 without ack -> err=1, IDLE next cycle, no hit.
REQ-032 err sticky; cleared only by RST; does not block further accesses.
REQ-033 Back-to-back: request still high in IDLE cycle after a hit is treated as new request (requester responsible for dropping it).

Reset
REQ-034 RST=1 at clock edge: state IDLE, last_grant=instr, wait counter 0, err 0, latched address/data/op 0.
REQ-035 During/after reset: ihit, dhit, ram_ren, ram_wen 0; ram_addr, ram_store, iload, dload 0.
REQ-036 RST mid-access (DACC/IACC): access abandoned, no hit, IDLE next cycle; ram_ack arriving after reset ignored.
REQ-037 RST dominates every concurrent request and ack.

Verification
REQ-038 RST=1 two cycles with iren=dren=1 -> all outputs 0; first grant after release is data.
REQ-039 iren=1, iaddr=0x40, ram_ack on 2nd enable cycle, ram_load=0xDEADBEEF -> ram_ren=1, ram_addr=0x40 two cycles; ihit=1, iload=0xDEADBEEF on ack cycle only.
REQ-040 iren=dren=dwen=0 then dwen=1, daddr=0x100, dstore=0x12345678, ack after 1 cycle -> ram_wen=1, ram_ren=0, ram_store=0x12345678, dhit one cycle.
REQ-041 iren and dren held continuously, ack every enable cycle -> grant order D,I,D,I; hits never overlap.
REQ-042 TIMEOUT=16, dren=1, ram_ack=0 -> ram_ren high exactly 16 cycles, then IDLE, no dhit, err=1 persists until RST.
REQ-043 dren dropped on 2nd cycle of DACC -> enables 0 next cycle, no dhit; RST during IACC then ram_ack -> no ihit.
